// File: rtl/ay_seq_pkg.sv
// ----------------------------------------------------------------------------
// ay_seq_pkg
// Shared definitions for the AY-3-8910 write sequencer:
//   - BC_* : {bdir,bc2,bc1} bus control codes
//   - MAX_CHIPS : largest number of chips on the shared bus
//   - seq_state_t : sequencer state encoding
//   - max3 : helper used to size the phase timer
// ----------------------------------------------------------------------------
package ay_seq_pkg;

   localparam logic [2:0] BC_INACT = 3'b000;
   localparam logic [2:0] BC_WRITE = 3'b110;
   localparam logic [2:0] BC_READ  = 3'b011;

   localparam int MAX_CHIPS = 4;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      A_PRE,
      A_ACT,
      A_POST,
      D_PRE,
      D_ACT,
      D_POST
   } seq_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ay_phase_timer.sv
// ----------------------------------------------------------------------------
// ay_phase_timer
// Loadable down-counter that times one bus phase.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val this cycle (phase entry)
//   load_val   : phase length minus one
//   done       : count has reached zero (last cycle of the phase)
// ----------------------------------------------------------------------------
module ay_phase_timer #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             done
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/ay_write_sequencer.sv
// ----------------------------------------------------------------------------
// ay_write_sequencer
// Plays per-frame register write records onto a shared AY-3-8910 bus,
// generating address-latch and data-write phases with programmable timing
// and omitting address phases whose register is already latched.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   frame_tick        : frame start pulse (overrun if not idle)
//   cmd_*             : record stream (valid/ready handshake)
//   bdir, bc2, bc1    : bus control code
//   da_out, da_oe     : shared data/address bus and its output enable
//   a8, a9_n          : chip-select address bits
//   busy              : sequencer not idle
//   overrun, overrun_cnt : late frame tick pulse and saturating count
// All outputs are registered.
// ----------------------------------------------------------------------------
module ay_write_sequencer
   import ay_seq_pkg::*;
#(
   parameter int         NUM_CHIPS  = 2,
   parameter logic [5:0] CHIP_ADDR0 = 6'h30,
   parameter int         PRE_CYC    = 1,
   parameter int         ACT_CYC    = 2,
   parameter int         POST_CYC   = 1,
   parameter logic [2:0] LATCH_CODE = 3'b111,
   parameter bit         SKIP_ADDR  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_chip,
   input  logic [3:0] cmd_reg,
   input  logic [7:0] cmd_data,
   input  logic       cmd_wr,
   input  logic       cmd_last,
   output logic       bdir,
   output logic       bc2,
   output logic       bc1,
   output logic [7:0] da_out,
   output logic       da_oe,
   output logic       a8,
   output logic       a9_n,
   output logic       busy,
   output logic       overrun,
   output logic [7:0] overrun_cnt
);

   localparam int TW = $clog2(max3(PRE_CYC, ACT_CYC, POST_CYC) + 1);

   seq_state_t    state, state_next;
   logic          timer_load, timer_done;
   logic [TW-1:0] timer_val;

   logic [1:0]    rec_chip;
   logic [3:0]    rec_reg;
   logic [7:0]    rec_data;
   logic          rec_last;

   logic [3:0]            latched_reg [MAX_CHIPS];
   logic [MAX_CHIPS-1:0]  latched_valid;

   logic       accept, chip_ok, skip_addr;
   logic [1:0] nxt_chip;
   logic [3:0] nxt_reg;
   logic [7:0] nxt_data;
   logic [5:0] nxt_addr;
   logic       nxt_addr_phase, nxt_data_phase;

   // cmd_ready is high exactly when the state is FETCH
   assign accept    = (state == FETCH) && cmd_valid;
   assign chip_ok   = ({1'b0, cmd_chip} < 3'(NUM_CHIPS));
   assign skip_addr = SKIP_ADDR && latched_valid[cmd_chip] &&
                      (latched_reg[cmd_chip] == cmd_reg);

   // Outputs are registered from the next state, so on the accept cycle the
   // bus fields must come from the incoming record rather than rec_*.
   assign nxt_chip = accept ? cmd_chip : rec_chip;
   assign nxt_reg  = accept ? cmd_reg  : rec_reg;
   assign nxt_data = accept ? cmd_data : rec_data;
   assign nxt_addr = CHIP_ADDR0 + 6'(nxt_chip);

   assign nxt_addr_phase = (state_next inside {A_PRE, A_ACT, A_POST});
   assign nxt_data_phase = (state_next inside {D_PRE, D_ACT, D_POST});

   ay_phase_timer #(.WIDTH(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (timer_val),
      .done     (timer_done)
   );

   always_comb begin
      state_next = state;
      timer_load = 1'b0;
      timer_val  = '0;

      case (state)
         IDLE:   if (frame_tick) state_next = FETCH;
         FETCH: begin
            if (accept) begin
               if (cmd_wr && chip_ok)
                  state_next = skip_addr ? D_PRE : A_PRE;
               else if (cmd_last)
                  state_next = IDLE;
            end
         end
         A_PRE:  if (timer_done) state_next = A_ACT;
         A_ACT:  if (timer_done) state_next = A_POST;
         A_POST: if (timer_done) state_next = D_PRE;
         D_PRE:  if (timer_done) state_next = D_ACT;
         D_ACT:  if (timer_done) state_next = D_POST;
         D_POST: if (timer_done) state_next = rec_last ? IDLE : FETCH;
         default: state_next = IDLE;
      endcase

      // Every phase change reloads the timer with the new phase length - 1
      if (state_next != state) begin
         timer_load = 1'b1;
         case (state_next)
            A_PRE,  D_PRE:  timer_val = TW'(PRE_CYC - 1);
            A_ACT,  D_ACT:  timer_val = TW'(ACT_CYC - 1);
            A_POST, D_POST: timer_val = TW'(POST_CYC - 1);
            default:        timer_val = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         rec_chip      <= '0;
         rec_reg       <= '0;
         rec_data      <= '0;
         rec_last      <= 1'b0;
         latched_valid <= '0;
         for (int i = 0; i < MAX_CHIPS; i++) latched_reg[i] <= '0;
         {bdir, bc2, bc1} <= BC_INACT;
         da_out        <= '0;
         da_oe         <= 1'b0;
         a8            <= 1'b0;
         a9_n          <= 1'b1;
         cmd_ready     <= 1'b0;
         busy          <= 1'b0;
         overrun       <= 1'b0;
         overrun_cnt   <= '0;
      end else begin
         state <= state_next;

         if (accept) begin
            rec_chip <= cmd_chip;
            rec_reg  <= cmd_reg;
            rec_data <= cmd_data;
            rec_last <= cmd_last;
         end

         // The chip has latched the register once its address strobe ends
         if (state == A_ACT && timer_done) begin
            latched_reg[rec_chip]   <= rec_reg;
            latched_valid[rec_chip] <= 1'b1;
         end

         case (state_next)
            A_ACT:   {bdir, bc2, bc1} <= LATCH_CODE;
            D_ACT:   {bdir, bc2, bc1} <= BC_WRITE;
            default: {bdir, bc2, bc1} <= BC_INACT;
         endcase

         da_oe <= nxt_addr_phase || nxt_data_phase;
         if (nxt_addr_phase)
            da_out <= {nxt_addr[3:0], nxt_reg};
         else if (nxt_data_phase)
            da_out <= nxt_data;
         else
            da_out <= '0;

         a8   <= (nxt_addr_phase || nxt_data_phase) ?  nxt_addr[4] : 1'b0;
         a9_n <= (nxt_addr_phase || nxt_data_phase) ? ~nxt_addr[5] : 1'b1;

         cmd_ready <= (state_next == FETCH);
         busy      <= (state_next != IDLE);

         // A tick on the last D_POST cycle still sees state != IDLE here
         overrun <= frame_tick && (state != IDLE);
         if (frame_tick && (state != IDLE) && (overrun_cnt != 8'hFF))
            overrun_cnt <= overrun_cnt + 8'd1;
      end
   end

endmodule
